onehot_req_arbiter: RTL and testbench
=====================================

# onehot_req_arbiter

Upstream stage for the 4-to-2 encoder. Takes four raw, asynchronous request lines (buttons or switches) and synchronizes and debounces them. It latches each rising edge as a pending request and serves pending requests one at a time in round-robin order. While a request is being served, its one-hot `grant` vector drives the encoder's a/b/c/d inputs, so the encoder never sees more than one bit set. A valid/ready handshake holds each grant until the downstream consumer accepts it.

## Interface
- `DB_CYCLES`, default 4: consecutive stable synchronized samples needed to change a debounced level; legal range ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_raw`  in  4  asynchronous raw requests; bit0 maps to encoder input a, bit3 to d.
- `ready`  in  1  downstream accepts the current grant.
- `grant`  out  4  one-hot grant to the encoder (bit0→a … bit3→d); all zeros when `valid` = 0.
- `valid`  out  1  `grant` holds a request.
- `pending`  out  4  latched, not-yet-served requests.
- `overrun`  out  1  one-cycle pulse: a new edge arrived on a line that was already pending.

## Operation
- Reset values: `grant` = 0, `valid` = 0, `pending` = 0, `overrun` = 0. Synchronizers, debounced levels and counters are all 0. Round-robin pointer = 3, so index 0 has first priority. FSM = IDLE.
- Synchronizer: 2 flops per bit; `s2` is the second stage.
- Debounce, per bit:
  - The counter increments on each edge where `s2` ≠ the debounced level `db`.
  - The counter clears to 0 on any edge where `s2` = `db`.
  - When the counter value is `DB_CYCLES`-1 and `s2` ≠ `db`, `db` toggles and the counter clears on that same edge.
  - Counter width is `$clog2(DB_CYCLES+1)`.
- Edge latch: on the edge where `db[i]` toggles 0→1, `pending[i]` is set.
  - If `pending[i]` is already 1 and is not being cleared on that edge, `overrun` pulses for 1 cycle and the request is dropped.
- FSM with two states:
  - IDLE: if `pending` ≠ 0, search `pending` starting at index ptr+1 (mod 4) and wrapping. The first set bit, k, is loaded into `grant` as a one-hot value, `valid` is set to 1, and the FSM moves to GRANT. If `pending` = 0, stay in IDLE.
  - GRANT: hold `grant` and `valid` stable while `ready` = 0. On `valid && ready`: clear `pending[k]`, set ptr = k, set `grant` = 0 and `valid` = 0, and return to IDLE.
- Simultaneous events:
  - New rising edge on line k on the same edge its grant is accepted: `pending[k]` ends at 1 (re-armed) and there is no `overrun`.
  - Edges on other lines during GRANT set their pending bits normally.
- Debounced falling edges do nothing except update `db`.
- `rst` asserted at any point, including during GRANT, returns everything to reset values on the next edge. In-flight and pending requests are discarded.

## Timing
- `req_raw[i]` rising and held stable → `pending[i]` = 1 after 2 + `DB_CYCLES` edges → `valid` = 1 one edge later. Total raw-to-valid latency is `DB_CYCLES` + 3 cycles.
- Glitch rejection: a pulse shorter than `DB_CYCLES` cycles at `s2` never changes `db`.
- Handshake: `grant` and `valid` are registered outputs. Acceptance occurs on the edge where `valid && ready`. The earliest next `valid` is 1 cycle after the acceptance edge, so peak throughput is 1 grant per 2 cycles.
- `ready` asserted while `valid` = 0 is ignored.

## Configuration
- `ONEHOT_ARB_DEBOUNCE_EN` defined: debounce counters are present as described above.
- `ONEHOT_ARB_DEBOUNCE_EN` undefined: counters are removed and `db` loads `s2` every cycle. Behaviour is identical to `DB_CYCLES` = 1, giving a raw-to-valid latency of 4 cycles. The `DB_CYCLES` parameter is ignored.

## Structure
- Shared package `onehot_arb_pkg`:
  - FSM state enum: IDLE, GRANT.
  - `NUM_REQ` = 4.
  - Pointer width `IDX_W` = 2.
- Sub-module `req_debounce`: one instance per bit, containing the synchronizer, counter and `db` register. It outputs `db` and a one-cycle `rise` strobe. The macro is applied inside this sub-module.
- The top level contains the pending register, round-robin search, FSM and output registers.

## Test plan
- Reset, then `req_raw` = 4'b0001 held, `DB_CYCLES` = 4 → `valid` = 1 with `grant` = 0001 exactly 7 cycles after the change. Hold `ready` = 0 for 5 cycles → `grant` stays stable. `ready` = 1 → `valid` = 0 and `pending` = 0 on the next edge.
- Glitch: `req_raw[2]` high for 3 cycles, `DB_CYCLES` = 4 → `pending` stays 0 and `valid` never rises. Repeat with the macro undefined → `grant` = 0100 after 4 cycles.
- `req_raw` = 4'b1111 rising together, `ready` held at 1 → grants are 0001, 0010, 0100, 1000, one every 2 cycles. After that, a new rise on bit 0 is granted next (pointer at 3).
- Overrun: bit 1 is pending while `valid` = 1 on bit 0; release and re-press bit 1 (each phase ≥ `DB_CYCLES` + 2 cycles) → `overrun` pulses exactly 1 cycle and bit 1 is granted once.
- Coincident edge: bit 3's new rise lands on the edge where grant 1000 is accepted → `pending[3]` = 1, no `overrun`, and 1000 is granted again 1 cycle later.
- `rst` pulsed for 1 cycle during GRANT with `pending` = 0110 → all outputs are 0 on the next edge. The first post-reset request on bit 3 is served normally.

Source files
------------

// File: rtl/onehot_arb_pkg.sv
// -----------------------------------------------------------------------------
// onehot_arb_pkg
// Shared definitions for the one-hot request arbiter:
//   NUM_REQ      number of request lines (fixed at 4, one per encoder input)
//   IDX_W        width of a request index / round-robin pointer
//   arb_state_e  arbiter FSM states (IDLE, GRANT)
//   rr_pick()    round-robin search helper
// -----------------------------------------------------------------------------
package onehot_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Returns the first set bit of req, searching from ptr+1 upward and wrapping,
  // so the most recently served index has the lowest priority. The caller only
  // uses the result when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx = ptr + IDX_W'(j);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/req_debounce.sv
// -----------------------------------------------------------------------------
// req_debounce
// Synchronizes one asynchronous request line (two flops) and debounces it.
// Configuration macro: ONEHOT_ARB_DEBOUNCE_EN
//   defined   : db changes only after DB_CYCLES consecutive synchronized samples
//               that differ from it.
//   undefined : no counter; db follows the synchronized input every cycle
//               (same behaviour as DB_CYCLES = 1), DB_CYCLES is ignored.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   i_raw   in   raw asynchronous request
//   o_db    out  debounced level
//   o_rise  out  high during the cycle whose closing edge takes db from 0 to 1
// -----------------------------------------------------------------------------
module req_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise
);

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("req_debounce: DB_CYCLES must be >= 1");
  end

  logic r_s1;
  logic r_s2;
  logic r_db;
  logic w_flip;

`ifdef ONEHOT_ARB_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // The edge that would complete the run toggles db instead of counting.
  assign w_flip = (r_s2 != r_db) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_s2 == r_db) || w_flip) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_flip = (r_s2 != r_db);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_db <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (w_flip) begin
        r_db <= r_s2;
      end
    end
  end

  // Combinational so the pending latch is set on the same edge db rises.
  assign o_rise = w_flip & r_s2;
  assign o_db   = r_db;

endmodule

// File: rtl/onehot_req_arbiter.sv
// -----------------------------------------------------------------------------
// onehot_req_arbiter
// Synchronizes and debounces four raw request lines, latches each debounced
// rising edge as a pending request and serves pending requests one at a time
// in round-robin order as a one-hot grant with a valid/ready handshake.
// Configuration macro: ONEHOT_ARB_DEBOUNCE_EN (applied inside req_debounce;
// when undefined the debounce counters are removed and DB_CYCLES is ignored).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   req_raw  in   [3:0] asynchronous raw requests (bit0 -> encoder a)
//   ready    in   downstream accepts the current grant
//   grant    out  [3:0] one-hot grant, zero when valid = 0
//   valid    out  grant holds a request
//   pending  out  [3:0] latched, not-yet-served requests
//   overrun  out  one-cycle pulse: new edge on a line already pending
// -----------------------------------------------------------------------------
module onehot_req_arbiter
  import onehot_arb_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_raw,
  input  logic               ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               overrun
);

  logic [NUM_REQ-1:0] w_rise;
  // Debounced levels are not needed here; only the rise strobes feed the latch.
  logic [NUM_REQ-1:0] w_db_unused;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    req_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_req_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (req_raw[gi]),
      .o_db   (w_db_unused[gi]),
      .o_rise (w_rise[gi])
    );
  end

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   w_gidx_nxt;
  logic [NUM_REQ-1:0] r_pending;
  logic               r_overrun;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_clr;
  logic [IDX_W-1:0]   w_pick;

  assign w_accept = r_valid & ready;
  // r_grant is one-hot on the served index, so it doubles as the clear mask.
  assign w_clr    = w_accept ? r_grant : '0;
  assign w_pick   = rr_pick(r_pending, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_state_nxt = GRANT;
          w_grant_nxt = NUM_REQ'(1) << w_pick;
          w_valid_nxt = 1'b1;
          w_gidx_nxt  = w_pick;
        end
      end
      GRANT: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_gidx;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_gidx    <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      // A rise coinciding with its own acceptance re-arms the line instead of
      // counting as an overrun.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_overrun <= |(w_rise & r_pending & ~w_clr);
    end
  end

  assign grant   = r_grant;
  assign valid   = r_valid;
  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
module tb_onehot_req_arbiter;

  localparam int DB = 4;
`ifdef ONEHOT_ARB_DEBOUNCE_EN
  localparam int EFF_DB = DB;
`else
  localparam int EFF_DB = 1;
`endif
  localparam int H = EFF_DB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_raw = 4'b0000;
  logic       ready = 1'b0;
  logic [3:0] grant;
  logic       valid;
  logic [3:0] pending;
  logic       overrun;

  always #5 clk = ~clk;

  onehot_req_arbiter #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_raw (req_raw),
    .ready   (ready),
    .grant   (grant),
    .valid   (valid),
    .pending (pending),
    .overrun (overrun)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [3:0] g; int c; } exp_t;
  exp_t sbq[$];
  logic [3:0] obs_q[$];

  logic [3:0] m_s1 = 0, m_s2 = 0, m_db = 0, m_pend = 0;
  int         m_run[4] = '{0, 0, 0, 0};
  bit         m_valid = 0, m_ovr = 0;
  int         m_gidx = 0, m_ptr = 3;
  int         cyc = 0;

  always @(posedge clk) begin : model
    logic [3:0] rise, clr;
    int k;
    cyc++;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_pend = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_valid = 0; m_ovr = 0; m_gidx = 0; m_ptr = 3;
      sbq.delete();
    end else begin
      rise = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] >= EFF_DB) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
            rise[i]  = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = req_raw;
      clr = 0;
      if (m_valid && ready) clr[m_gidx] = 1'b1;
      if (m_valid) begin
        if (ready) begin
          m_valid = 0;
          m_ptr   = m_gidx;
        end
      end else if (m_pend != 0) begin
        for (int j = 1; j <= 4; j++) begin
          k = (m_ptr + j) % 4;
          if (m_pend[k]) begin
            m_gidx = k;
            break;
          end
        end
        m_valid = 1;
        sbq.push_back('{g: 4'b0001 << m_gidx, c: cyc});
      end
      m_ovr  = |(rise & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | rise;
    end
  end

  // ---------------- monitor ----------------
  bit prev_valid = 0;
  int ovr_cnt = 0;
  int acc_cnt[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin : monitor
    exp_t e;
    check("pending", pending, m_pend);
    check("overrun", overrun, m_ovr);
    check("valid", valid, m_valid);
    check("grant", grant, m_valid ? (4'b0001 << m_gidx) : 4'b0000);
    if (valid && !prev_valid) begin
      obs_q.push_back(grant);
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL grant_issue: got grant %0h, expected no new grant", grant);
      end else begin
        e = sbq.pop_front();
        check("issued_grant", grant, e.g);
        check("issue_cycle", cyc, e.c);
      end
    end
    prev_valid = valid;
    if (overrun) ovr_cnt++;
  end

  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      for (int i = 0; i < 4; i++) if (grant[i]) acc_cnt[i]++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_acc();
    for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: valid not seen within 50 cycles, required 1", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    check("reset_valid", valid, 0);
    check("reset_pending", pending, 0);

    // Latency and hold-while-not-ready
    req_raw = 4'b0001;
    n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("raw_to_valid_latency", n, EFF_DB + 3);
    check("first_grant", grant, 4'b0001);
    cycles(5);
    check("grant_held", grant, 4'b0001);
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
    check("accept_valid", valid, 0);
    check("accept_pending", pending, 0);
    req_raw = 4'b0000;
    cycles(H);

    // Glitch of 3 cycles on bit 2
    clr_acc();
    req_raw = 4'b0100;
    cycles(3);
    req_raw = 4'b0000;
    ready = 1'b1;
    cycles(12);
    ready = 1'b0;
    check("glitch_grants", acc_cnt[2], (EFF_DB > 3) ? 0 : 1);

    // All four together, pointer fresh from reset
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    obs_q.delete();
    ready = 1'b1;
    req_raw = 4'b1111;
    cycles(EFF_DB + 13);
    req_raw = 4'b0000;
    cycles(H);
    req_raw = 4'b0001;
    cycles(H);
    req_raw = 4'b0000;
    cycles(H);
    check("rr_count", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      check("rr_0", obs_q[0], 4'b0001);
      check("rr_1", obs_q[1], 4'b0010);
      check("rr_2", obs_q[2], 4'b0100);
      check("rr_3", obs_q[3], 4'b1000);
      check("rr_4", obs_q[4], 4'b0001);
    end

    // Overrun: re-press a line that is still pending
    ready = 1'b0;
    ovr_cnt = 0;
    clr_acc();
    req_raw = 4'b0011;
    cycles(H + 3);
    req_raw = 4'b0001;
    cycles(H);
    req_raw = 4'b0011;
    cycles(H);
    check("overrun_pulses", ovr_cnt, 1);
    ready = 1'b1;
    cycles(8);
    ready = 1'b0;
    check("overrun_bit1_grants", acc_cnt[1], 1);
    check("overrun_bit0_grants", acc_cnt[0], 1);
    req_raw = 4'b0000;
    cycles(H);

    // Coincident re-press landing on the acceptance edge
    ovr_cnt = 0;
    req_raw = 4'b1000;
    wait_valid("coincident_first_grant");
    req_raw = 4'b0000;
    cycles(H);
    req_raw = 4'b1000;
    cycles(1 + EFF_DB);
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
    check("coincident_pending", pending, 4'b1000);
    check("coincident_valid_low", valid, 0);
    cycles(1);
    check("coincident_regrant_valid", valid, 1);
    check("coincident_regrant", grant, 4'b1000);
    check("coincident_no_overrun", ovr_cnt, 0);
    ready = 1'b1;
    cycles(2);
    ready = 1'b0;
    req_raw = 4'b0000;
    cycles(H);

    // Reset during GRANT with two lines pending
    req_raw = 4'b0110;
    cycles(H + 2);
    check("pre_reset_pending", pending, 4'b0110);
    check("pre_reset_valid", valid, 1);
    rst = 1'b1;
    req_raw = 4'b0000;
    cycles(1);
    rst = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_valid", valid, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    clr_acc();
    req_raw = 4'b1000;
    ready = 1'b1;
    cycles(H);
    check("post_reset_bit3_grants", acc_cnt[3], 1);
    check("post_reset_other_grants", acc_cnt[1] + acc_cnt[2], 0);
    req_raw = 4'b0000;
    ready = 1'b0;
    cycles(H);

    // Randomized traffic checked against the model
    for (int t = 0; t < 80; t++) begin
      req_raw = 4'($urandom_range(0, 15));
      n = $urandom_range(1, EFF_DB + 4);
      for (int c = 0; c < n; c++) begin
        ready = 1'($urandom_range(0, 1));
        rst = ($urandom_range(0, 60) == 0);
        @(negedge clk);
      end
      rst = 1'b0;
    end
    req_raw = 4'b0000;
    ready = 1'b1;
    cycles(30);
    check("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
